systolic_skewer: RTL and testbench
==================================

SYSTOLIC_SKEWER -- requirements
Module: systolic_skewer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of parallel data lanes (rows/columns of the array).
REQ-002 SHALL have parameter DATA_SIZE, default 32, bits per lane.
REQ-003 SHALL have parameter BASE_DELAY, default 0, delay in advance cycles added to every lane.
REQ-004 SHALL have parameter DESKEW, default 0: 0 selects skew (input side), 1 selects deskew (output side).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data beat offered.
REQ-008 SHALL have port in_ready, output, 1 bit: beat accepted this cycle when in_valid is also high.
REQ-009 SHALL have port in_last, input, 1 bit: accepted beat is the final beat of the block.
REQ-010 SHALL have port in_data, input, NUM_LANES x DATA_SIZE: one word per lane.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream can take data; global advance enable.
REQ-012 SHALL have port out_valid, output, NUM_LANES bits: per-lane valid of out_data.
REQ-013 SHALL have port out_data, output, NUM_LANES x DATA_SIZE: skewed/deskewed words.
REQ-014 SHALL have port busy, output, 1 bit: valid data in flight or drain in progress.
REQ-015 SHALL have port drain_done, output, 1 bit: one-cycle pulse when the last beat has left every lane.

Function
REQ-016 SHALL define lane delay D(i) = BASE_DELAY + i when DESKEW=0, and BASE_DELAY + (NUM_LANES-1-i) when DESKEW=1; D_MAX = BASE_DELAY + NUM_LANES-1.
REQ-017 SHALL define an advance cycle as any cycle with out_ready=1; with out_ready=0, all lane contents, out_valid, out_data and the FSM SHALL hold.
REQ-018 SHALL, on each advance cycle, shift every lane one stage, inserting the accepted beat (valid=1) or a bubble (valid=0) when no beat is accepted.
REQ-019 SHALL present lane i's word accepted on advance cycle t at out_data[i] with out_valid[i]=1 on advance cycle t+D(i); a lane with D(i)=0 SHALL be a combinational pass-through gated by in_valid&&in_ready.
REQ-020 SHALL drive in_ready = out_ready AND (state != DRAIN).
REQ-021 SHALL implement FSM states IDLE, STREAM and DRAIN, with the following transitions:
- IDLE->STREAM on an accepted beat without in_last.
- IDLE or STREAM -> DRAIN on an accepted beat with in_last.
- DRAIN->IDLE when the drain counter reaches 0 on an advance cycle.
REQ-022 SHALL load the drain counter with D_MAX on entry to DRAIN and decrement it by 1 per advance cycle.
REQ-023 SHALL pulse drain_done for exactly one cycle on the DRAIN->IDLE transition; with D_MAX=0, an accepted in_last beat SHALL go directly to IDLE and pulse drain_done in the following cycle.
REQ-024 SHALL drive busy=1 in STREAM and DRAIN, or whenever any lane stage holds valid=1.
REQ-025 SHALL accept in_last with in_valid=1 in IDLE; beats offered during DRAIN SHALL NOT be accepted and SHALL cause no state change.

Reset
REQ-026 SHALL, on a cycle with reset=1, clear all lane stages (data 0, valid 0), enter IDLE, clear the drain counter, and drive out_valid=0, out_data=0, drain_done=0, busy=0, regardless of out_ready.
REQ-027 SHALL discard in-flight data when reset is asserted mid-STREAM or mid-DRAIN, without producing a drain_done pulse.

Configuration
REQ-028 SHALL support macro SYSTOLIC_SKEWER_ZERO_FILL_EN: when defined, out_data[i] SHALL be 0 whenever out_valid[i]=0; when undefined, out_data[i] with out_valid[i]=0 SHALL be don't-care, and bubble stages SHALL skip their data-register write.

Structure
REQ-029 SHALL place the FSM state enum typedef and a lane_delay(i, NUM_LANES, BASE_DELAY, DESKEW) constant function in package skewer_pkg.
REQ-030 SHALL instantiate one sub-module per lane, skew_lane: parametrised-depth shift register with valid bit, enable and synchronous reset, depth 0 allowed.

Verification
REQ-031 SHALL test: NUM_LANES=4, BASE_DELAY=0, DESKEW=0, out_ready=1, beats A,B,C (C last) -> lane 3 emits A on cycle 3 relative to lane 0; drain_done 3 cycles after C accepted.
REQ-032 SHALL test: DESKEW=1, same stimulus -> lane 0 delay 3, lane 3 delay 0; a skewed stream fed in reappears column-aligned.
REQ-033 SHALL test: out_ready=0 for 5 cycles mid-stream -> all outputs hold; in_ready=0; no data lost or duplicated.
REQ-034 SHALL test: in_valid held high during DRAIN -> in_ready=0; no beat accepted; next block accepted only after drain_done.
REQ-035 SHALL test: reset asserted mid-DRAIN with BASE_DELAY=2 -> next cycle all out_valid=0, busy=0, no drain_done.
REQ-036 SHALL test: with SYSTOLIC_SKEWER_ZERO_FILL_EN defined, a sparse input (bubbles between beats) -> out_data exactly 0 on every lane whenever its out_valid=0.

Source files
------------

// File: rtl/skewer_pkg.sv
// ---------------------------------------------------------------------------
// skewer_pkg
// Shared definitions for the systolic skew/deskew block.
//   skew_state_e : sequencing FSM state encoding (IDLE / STREAM / DRAIN)
//   lane_delay() : per-lane delay in advance cycles, usable in constant
//                  expressions when sizing the per-lane shift registers.
// ---------------------------------------------------------------------------
package skewer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } skew_state_e;

    // Skew side delays lane i by i stages, so lane 0 leads. The deskew side
    // undoes that by delaying lane i by the complementary amount.
    function automatic int lane_delay(input int lane,
                                      input int num_lanes,
                                      input int base_delay,
                                      input int deskew);
        if (deskew != 0) begin
            return base_delay + (num_lanes - 1 - lane);
        end
        return base_delay + lane;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// ---------------------------------------------------------------------------
// skew_lane
// One lane of the skewer: a DEPTH-stage shift register carrying a valid bit
// alongside each data word. DEPTH = 0 degenerates to a wire.
//
// Build option: SYSTOLIC_SKEWER_ZERO_FILL_EN
//   defined   - data_o is forced to 0 whenever valid_o is 0.
//   undefined - data behind a bubble is left stale; bubble stages do not
//               write their data register.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears valid and data
//   en_i     : advance enable; all stages hold when low
//   valid_i  : word on data_i enters the lane on this advance
//   data_i   : lane input word
//   valid_o  : word on data_o is valid
//   data_o   : lane output word
//   busy_o   : at least one stage holds a valid word
// ---------------------------------------------------------------------------
module skew_lane #(
    parameter int DEPTH     = 1,
    parameter int DATA_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 busy_o
);

    generate
        if (DEPTH == 0) begin : g_thru
            // No storage: clock, reset and enable have no function here.
            logic unused_seq;
            assign unused_seq = ^{clk_i, rst_i, en_i};

            assign valid_o = valid_i;
            assign busy_o  = 1'b0;
`ifdef SYSTOLIC_SKEWER_ZERO_FILL_EN
            assign data_o  = valid_i ? data_i : '0;
`else
            assign data_o  = data_i;
`endif
        end else begin : g_sr
            logic [DEPTH-1:0]     vld_q;
            logic [DATA_SIZE-1:0] dat_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        dat_q[j] <= '0;
                    end
                end else if (en_i) begin
                    vld_q[0] <= valid_i;
                    for (int j = 1; j < DEPTH; j++) begin
                        vld_q[j] <= vld_q[j-1];
                    end
`ifdef SYSTOLIC_SKEWER_ZERO_FILL_EN
                    dat_q[0] <= data_i;
                    for (int j = 1; j < DEPTH; j++) begin
                        dat_q[j] <= dat_q[j-1];
                    end
`else
                    // Only a valid word is worth moving; a bubble leaves the
                    // downstream data register untouched.
                    if (valid_i) begin
                        dat_q[0] <= data_i;
                    end
                    for (int j = 1; j < DEPTH; j++) begin
                        if (vld_q[j-1]) begin
                            dat_q[j] <= dat_q[j-1];
                        end
                    end
`endif
                end
            end

            assign valid_o = vld_q[DEPTH-1];
            assign busy_o  = |vld_q;
`ifdef SYSTOLIC_SKEWER_ZERO_FILL_EN
            assign data_o  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
`else
            assign data_o  = dat_q[DEPTH-1];
`endif
        end
    endgenerate

endmodule

// File: rtl/systolic_skewer.sv
// ---------------------------------------------------------------------------
// systolic_skewer
// Staggers (DESKEW=0) or re-aligns (DESKEW=1) a NUM_LANES-wide word stream
// for a systolic array. Lane i is delayed by lane_delay(i) advance cycles; an
// advance cycle is any cycle with out_ready high. A small FSM tracks the
// block framing so that after the last beat the input is closed until every
// lane has emptied, then drain_done pulses.
//
// Build option: SYSTOLIC_SKEWER_ZERO_FILL_EN
//   defined   - out_data[i] reads 0 whenever out_valid[i] is 0.
//   undefined - out_data[i] is don't-care while out_valid[i] is 0.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_valid   : beat offered on in_data
//   in_ready   : beat taken this cycle when in_valid is also high
//   in_last    : the accepted beat closes the block
//   in_data    : one word per lane
//   out_ready  : downstream can take data; global advance enable
//   out_valid  : per-lane valid of out_data
//   out_data   : skewed / deskewed words
//   busy       : block open, draining, or any lane holding valid data
//   drain_done : one-cycle pulse after the last beat has left every lane
//
// FSM
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no block open; waiting for the first beat
//   ST_STREAM | block open, beats being accepted
//   ST_DRAIN  | last beat taken; input closed while lanes empty out
// ---------------------------------------------------------------------------
module systolic_skewer
    import skewer_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_SIZE  = 32,
    parameter int BASE_DELAY = 0,
    parameter int DESKEW     = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [NUM_LANES-1:0][DATA_SIZE-1:0] in_data,
    input  logic                                out_ready,
    output logic [NUM_LANES-1:0]                out_valid,
    output logic [NUM_LANES-1:0][DATA_SIZE-1:0] out_data,
    output logic                                busy,
    output logic                                drain_done
);

    localparam int D_MAX = BASE_DELAY + NUM_LANES - 1;
    localparam int CNT_W = (D_MAX < 1) ? 1 : $clog2(D_MAX + 1);

    skew_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;

    logic [NUM_LANES-1:0]                lane_valid;
    logic [NUM_LANES-1:0]                lane_busy;
    logic [NUM_LANES-1:0][DATA_SIZE-1:0] lane_data;

    assign in_ready = out_ready && (state_q != ST_DRAIN);
    // A beat presented in a reset cycle must not reach the pass-through lanes.
    assign accept   = in_valid && in_ready && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (out_ready) begin
            unique case (state_q)
                ST_IDLE, ST_STREAM: begin
                    if (accept) begin
                        if (in_last) begin
                            if (D_MAX == 0) begin
                                // Nothing is stored anywhere; the block is
                                // already out.
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_DRAIN;
                                cnt_d   = CNT_W'(D_MAX);
                            end
                        end else begin
                            state_d = ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int LD = lane_delay(gi, NUM_LANES, BASE_DELAY, DESKEW);

            skew_lane #(
                .DEPTH     (LD),
                .DATA_SIZE (DATA_SIZE)
            ) u_lane (
                .clk_i   (clk),
                .rst_i   (reset),
                .en_i    (out_ready),
                .valid_i (accept),
                .data_i  (in_data[gi]),
                .valid_o (lane_valid[gi]),
                .data_o  (lane_data[gi]),
                .busy_o  (lane_busy[gi])
            );
        end
    endgenerate

    // Outputs read as idle during the reset cycle itself, not only after it.
    assign out_valid  = reset ? '0 : lane_valid;
    assign out_data   = reset ? '0 : lane_data;
    assign busy       = !reset && ((state_q != ST_IDLE) || (|lane_busy));
    assign drain_done = !reset && done_q;

endmodule

// File: tb/tb_systolic_skewer.sv
module tb_systolic_skewer;

    localparam int NL = 4;
    localparam int DW = 32;
    localparam int NI = 3;
    localparam int HN = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   iv;
    logic                   il;
    logic                   ordy;
    logic [NL-1:0][DW-1:0]  din;

    logic                   rdy  [NI];
    logic [NL-1:0]          ov   [NI];
    logic [NL-1:0][DW-1:0]  od   [NI];
    logic                   bsy  [NI];
    logic                   dd   [NI];

    // u0: skew, base 0 | u1: deskew, base 0 | u2: skew, base 2
    systolic_skewer #(.NUM_LANES(NL), .DATA_SIZE(DW), .BASE_DELAY(0), .DESKEW(0)) u_dut0 (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy[0]), .in_last(il),
        .in_data(din), .out_ready(ordy), .out_valid(ov[0]), .out_data(od[0]),
        .busy(bsy[0]), .drain_done(dd[0]));
    systolic_skewer #(.NUM_LANES(NL), .DATA_SIZE(DW), .BASE_DELAY(0), .DESKEW(1)) u_dut1 (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy[1]), .in_last(il),
        .in_data(din), .out_ready(ordy), .out_valid(ov[1]), .out_data(od[1]),
        .busy(bsy[1]), .drain_done(dd[1]));
    systolic_skewer #(.NUM_LANES(NL), .DATA_SIZE(DW), .BASE_DELAY(2), .DESKEW(0)) u_dut2 (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy[2]), .in_last(il),
        .in_data(din), .out_ready(ordy), .out_valid(ov[2]), .out_data(od[2]),
        .busy(bsy[2]), .drain_done(dd[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: beats recorded per advance-cycle index; a lane with
    // delay D shows the beat taken D advances ago.
    bit                    hv [NI][HN];
    logic [NL-1:0][DW-1:0] hd [NI][HN];
    int                    nadv     [NI];
    int                    last_idx [NI];
    bit                    strm     [NI];
    bit                    done_exp [NI];

    function automatic int base_of(input int k);
        return (k == 2) ? 2 : 0;
    endfunction

    function automatic int dmax_of(input int k);
        return base_of(k) + NL - 1;
    endfunction

    function automatic int dly(input int k, input int i);
        return (k == 1) ? base_of(k) + (NL - 1 - i) : base_of(k) + i;
    endfunction

    function automatic bit draining(input int k);
        return (last_idx[k] >= 0) && (nadv[k] <= last_idx[k] + dmax_of(k));
    endfunction

    function automatic bit exp_ready(input int k);
        return ordy && !draining(k);
    endfunction

    task automatic reset_model(input int k);
        nadv[k]     = 0;
        last_idx[k] = -1;
        strm[k]     = 1'b0;
        done_exp[k] = 1'b0;
        for (int j = 0; j < HN; j++) hv[k][j] = 1'b0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NI; k++) begin
            logic [NL-1:0]         ev;
            logic [NL-1:0][DW-1:0] ed;
            bit                    eb;
            ev = '0;
            ed = '0;
            eb = strm[k] || draining(k);
            for (int m = nadv[k] - dmax_of(k); m < nadv[k]; m++)
                if (m >= 0 && hv[k][m]) eb = 1'b1;
            for (int i = 0; i < NL; i++) begin
                int d;
                int idx;
                d = dly(k, i);
                if (d == 0) begin
                    ev[i] = iv && exp_ready(k);
                    ed[i] = din[i];
                end else begin
                    idx = nadv[k] - d;
                    if (idx >= 0) begin
                        ev[i] = hv[k][idx];
                        ed[i] = hd[k][idx][i];
                    end
                end
            end
            check($sformatf("u%0d.in_ready", k), 128'(rdy[k]), 128'(exp_ready(k)));
            if (rst) begin
                check($sformatf("u%0d.rst_out_valid", k), 128'(ov[k]), 128'(0));
                check($sformatf("u%0d.rst_out_data", k), 128'(od[k]), 128'(0));
                check($sformatf("u%0d.rst_busy", k), 128'(bsy[k]), 128'(0));
                check($sformatf("u%0d.rst_drain_done", k), 128'(dd[k]), 128'(0));
            end else begin
                check($sformatf("u%0d.out_valid", k), 128'(ov[k]), 128'(ev));
                check($sformatf("u%0d.busy", k), 128'(bsy[k]), 128'(eb));
                check($sformatf("u%0d.drain_done", k), 128'(dd[k]), 128'(done_exp[k]));
                for (int i = 0; i < NL; i++) begin
                    if (ev[i]) begin
                        check($sformatf("u%0d.out_data[%0d]", k, i), 128'(od[k][i]), 128'(ed[i]));
                    end else begin
`ifdef SYSTOLIC_SKEWER_ZERO_FILL_EN
                        check($sformatf("u%0d.zero_fill[%0d]", k, i), 128'(od[k][i]), 128'(0));
`endif
                    end
                end
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                reset_model(k);
            end else if (ordy) begin
                bit acc;
                acc = iv && exp_ready(k);
                hv[k][nadv[k]] = acc;
                hd[k][nadv[k]] = din;
                if (acc && il) begin
                    last_idx[k] = nadv[k];
                    strm[k]     = 1'b0;
                end else if (acc) begin
                    strm[k] = 1'b1;
                end
                done_exp[k] = (last_idx[k] >= 0) && (nadv[k] == last_idx[k] + dmax_of(k));
                nadv[k]++;
            end else begin
                done_exp[k] = 1'b0;
            end
        end
    endtask

    task automatic run_cycle(input logic r, input logic v, input logic l, input logic o,
                             input logic [NL-1:0][DW-1:0] d);
        rst  = r;
        iv   = v;
        il   = l;
        ordy = o;
        din  = d;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [NL-1:0][DW-1:0] rnd_word();
        logic [NL-1:0][DW-1:0] w;
        for (int i = 0; i < NL; i++) w[i] = $urandom;
        return w;
    endfunction

    function automatic logic [NL-1:0][DW-1:0] tag_word(input int b);
        logic [NL-1:0][DW-1:0] w;
        for (int i = 0; i < NL; i++) w[i] = 32'(b * 16 + i);
        return w;
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) reset_model(k);
        rst = 1'b1; iv = 1'b0; il = 1'b0; ordy = 1'b1; din = '0;

        // Reset, including one cycle with out_ready low.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_word());
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Beats A, B, C (C last) with out_ready high, then let every lane empty.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(10));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(11));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, tag_word(12));
        for (int c = 0; c < 9; c++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Stall for 5 cycles mid-stream with a beat still offered.
        for (int b = 0; b < 3; b++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(20 + b));
        for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, tag_word(23));
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(23));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, tag_word(24));

        // in_valid held through the drain; the next block waits for drain_done.
        for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(30 + c));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, tag_word(40));
        for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Reset in the middle of a drain (deepest drain on the base-2 instance).
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, tag_word(50));
        run_cycle(1'b0, 1'b1, 1'b1, 1'b1, tag_word(51));
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Sparse beats with bubbles between them.
        for (int b = 0; b < 6; b++) begin
            run_cycle(1'b0, 1'b1, (b == 5), 1'b1, rnd_word());
            run_cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd_word());
            run_cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd_word());
        end
        for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            logic r, v, l, o;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 99) < 60);
            l = ($urandom_range(0, 99) < 15);
            o = ($urandom_range(0, 99) < 75);
            run_cycle(r, v, l, o, rnd_word());
        end
        for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
